// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the "101" serial transmitter slice.
//   seq_state_e   FSM state encoding (IDLE=0, PRE=1, DATA=2).
//   SEQ_PREAMBLE  sync pattern, sent MSB-first as 1,0,1.
//   SEQ_PRE_LEN   number of preamble bits.
//   seq_pre_bit() preamble bit for a given position (0 = first bit sent).
// Build macro: SEQ_TX_PREAMBLE_EN. When it is undefined, the PRE state and
// the preamble constants are not declared.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef SEQ_TX_PREAMBLE_EN
        PRE  = 2'd1,
`endif
        DATA = 2'd2
    } seq_state_e;

`ifdef SEQ_TX_PREAMBLE_EN
    localparam logic [2:0]  SEQ_PREAMBLE = 3'b101;
    localparam int unsigned SEQ_PRE_LEN  = 3;

    function automatic logic seq_pre_bit(input logic [1:0] idx);
        return SEQ_PREAMBLE[2'd2 - idx];
    endfunction
`endif

endpackage

// File: rtl/seq_piso.sv
// seq_piso: parallel-load, MSB-first shift register.
//   clk      rising-edge clock
//   rst      synchronous active-high reset (clears the register)
//   i_load   capture i_data (takes priority over i_shift)
//   i_shift  shift left by one and fill the LSB with 0
//   i_data   parallel load word
//   o_msb    current MSB; this is the next bit to be transmitted
module seq_piso #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {r_sh[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_sh[WIDTH-1];

endmodule

// File: rtl/seq_tx_101.sv
// seq_tx_101: serial frame transmitter for "101" sequence detectors.
// It accepts a word through a valid/ready handshake and sends it MSB-first,
// one bit per clock. When built with the preamble, each frame starts with 1,0,1.
//   WIDTH        payload bits per frame (2..32)
//   clk          rising-edge clock
//   rst          synchronous active-high reset; aborts any frame in flight
//   in_data      payload word, sampled only on a transfer edge
//   in_valid     in_data is offered
//   in_ready     word accepted this cycle (combinational from state/counter)
//   out          serial bit (registered), 0 whenever out_valid is 0
//   out_valid    out carries a frame bit (registered)
//   frame_start  pulse on the first bit of a frame (registered)
//   frame_done   pulse on the last payload bit (registered)
// Build macro: SEQ_TX_PREAMBLE_EN enables the PRE state and the 1-0-1 preamble.
module seq_tx_101
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_done
);

    // The counter must also reach the preamble's last index (2), so it is at
    // least 2 bits wide in preamble builds, even for WIDTH=2.
`ifdef SEQ_TX_PREAMBLE_EN
    localparam int unsigned CW = ($clog2(WIDTH) > 2) ? $clog2(WIDTH) : 2;
`else
    localparam int unsigned CW = $clog2(WIDTH);
`endif
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    seq_state_e       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_out, w_out_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_start, w_start_nxt;
    logic             r_done, w_done_nxt;
    logic             w_xfer;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;
    logic [WIDTH-1:0] w_load_data;

    assign in_ready = (r_state == IDLE) || ((r_state == DATA) && (r_cnt == LAST));
    assign w_xfer   = in_valid && in_ready;

    // Without a preamble the MSB goes straight to the output register on the
    // transfer edge, so the shifter is loaded one position ahead.
`ifdef SEQ_TX_PREAMBLE_EN
    assign w_load_data = in_data;
`else
    assign w_load_data = {in_data[WIDTH-2:0], 1'b0};
`endif

    seq_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_load_data),
        .o_msb   (w_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_start <= w_start_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // r_cnt indexes the bit currently on out within the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_start_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;

        case (r_state)
            IDLE: begin
            end
`ifdef SEQ_TX_PREAMBLE_EN
            PRE: begin
                w_valid_nxt = 1'b1;
                if (r_cnt == CW'(SEQ_PRE_LEN - 1)) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = w_msb;
                    w_shift     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    w_out_nxt = seq_pre_bit(r_cnt[1:0] + 2'd1);
                end
            end
`endif
            DATA: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_out_nxt   = w_msb;
                    w_shift     = 1'b1;
                    w_done_nxt  = (r_cnt == LAST - CW'(1));
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // A transfer only happens in IDLE or on the last payload bit. Handling
        // it here covers both the idle start and the back-to-back reload.
        if (w_xfer) begin
            w_load      = 1'b1;
            w_shift     = 1'b0;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_start_nxt = 1'b1;
            w_done_nxt  = 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
            w_state_nxt = PRE;
            w_out_nxt   = seq_pre_bit(2'd0);
`else
            w_state_nxt = DATA;
            w_out_nxt   = in_data[WIDTH-1];
`endif
        end
    end

    assign out         = r_out;
    assign out_valid   = r_valid;
    assign frame_start = r_start;
    assign frame_done  = r_done;

endmodule

// File: tb/tb_seq_tx_101.sv
module tb_seq_tx_101;

    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } exp_bit_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out;
    logic       out_valid;
    logic       frame_start;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    exp_bit_t q[$];

    logic        det_en = 1'b0;
    logic [1:0]  det_hist = '0;
    logic [15:0] det_mask = '0;
    logic [15:0] det_exp;
    int          det_idx = 0;
    int          pre_len;

    seq_tx_101 #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_bit_t e;
`ifdef SEQ_TX_PREAMBLE_EN
        e = '{b: 1'b1, s: 1'b1, d: 1'b0}; q.push_back(e);
        e = '{b: 1'b0, s: 1'b0, d: 1'b0}; q.push_back(e);
        e = '{b: 1'b1, s: 1'b0, d: 1'b0}; q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            e = '{b: d[i], s: 1'b0, d: (i == 0)};
            q.push_back(e);
        end
`else
        for (int i = 7; i >= 0; i--) begin
            e = '{b: d[i], s: (i == 7), d: (i == 0)};
            q.push_back(e);
        end
`endif
    endtask

    // One clock: drive inputs, update the model at the edge, check #1 later.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic     m_ready;
        exp_bit_t e;
        logic     ev;
        in_valid = v;
        in_data  = d;
        rst      = r;
        m_ready  = (q.size() == 0);
        @(posedge clk);
        if (r) q.delete();
        else if (v && m_ready) push_frame(d);
        #1;
        if (q.size() != 0) begin
            e  = q.pop_front();
            ev = 1'b1;
        end else begin
            e  = '0;
            ev = 1'b0;
        end
        chk("out_valid", out_valid, ev);
        chk("out", out, e.b);
        chk("frame_start", frame_start, e.s);
        chk("frame_done", frame_done, e.d);
        chk("in_ready", in_ready, (q.size() == 0));
        if (det_en) begin
            if (out_valid) begin
                if (out && det_hist == 2'b10) det_mask[det_idx[3:0]] = 1'b1;
                det_hist = {det_hist[0], out};
                det_idx++;
            end else begin
                det_hist = '0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && q.size() != 0; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
`ifdef SEQ_TX_PREAMBLE_EN
        pre_len = 3;
        det_exp = 16'h0404;
`else
        pre_len = 0;
        det_exp = 16'h0080;
`endif
        // reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // reset together with a transfer: word is dropped
        step(1'b1, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // single frame A5
        step(1'b1, 8'hA5, 1'b0);
        drain();
        step(1'b0, 8'h00, 1'b0);

        // back-to-back FF then 00 offered during frame_done
        step(1'b1, 8'hFF, 1'b0);
        drain();
        step(1'b1, 8'h00, 1'b0);
        drain();
        step(1'b0, 8'h00, 1'b0);

        // valid held while busy with changing data
        step(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 64 && q.size() != 0; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // reset during the 5th payload bit, then a fresh frame
        step(1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < pre_len + 4; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        drain();
        step(1'b0, 8'h00, 1'b0);

        // 81: first and last bit set
        step(1'b1, 8'h81, 1'b0);
        drain();
        step(1'b0, 8'h00, 1'b0);

        // loopback through an overlapping "101" detector
        det_en   = 1'b1;
        det_hist = '0;
        det_idx  = 0;
        det_mask = '0;
        step(1'b1, 8'h05, 1'b0);
        drain();
        det_en = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("det_pulse[%0d]", i), det_mask[i], det_exp[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
